// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that owns the select of a 4:1 mux channel. One
//   requester is granted at a time and keeps the grant for a burst of at
//   most MAX_BURST beats (a beat is a cycle with out_valid && out_ready).
//   After every release the arbiter spends exactly one cycle in IDLE before
//   it grants again. The scan for the next grant starts one past the last
//   granted port.
//
//   Ports
//     clk        in   1    clock, rising edge
//     rst_n      in   1    asynchronous active-low reset
//     req        in   4    request, req[i] belongs to d<i>
//     d0..d3     in   DW   requester data
//     out_ready  in   1    downstream accepts beat
//     gnt        out  4    one-hot grant, registered
//     sel        out  2    index of granted requester, registered
//     out_valid  out  1    beat on y is valid
//     y          out  DW   muxed data, y = d[sel]
//     busy       out  1    high while a grant is held
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; arbitrates pending requests on the next edge
//   GRANT | sel owns the channel until its req drops or the burst ends

module mux4_1 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] sel,
    output logic       y
);
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int DW        = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    input  logic          out_ready,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          out_valid,
    output logic [DW-1:0] y,
    output logic          busy
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] count_q, count_d;

    logic       beat;
    logic       found;
    logic [1:0] pick;

    // First set request scanning ptr, ptr+1, ... with 2-bit wraparound.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] cand;
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign out_valid = (state_q == GRANT) && req[sel_q];
    assign beat      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick;
                    sel_d   = pick;
                    count_d = 4'd0;
                end
            end
            GRANT: begin
                // A dropped request releases even with out_ready low.
                if (!req[sel_q] || (beat && count_q == LAST_BEAT)) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                    count_d = 4'd0;
                end else if (beat) begin
                    count_d = count_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                count_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);

    for (genvar b = 0; b < DW; b++) begin : g_mux
        mux4_1 u_mux (
            .d0  (d0[b]),
            .d1  (d1[b]),
            .d2  (d2[b]),
            .d3  (d3[b]),
            .sel (sel_q),
            .y   (y[b])
        );
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] d0, d1, d2, d3;
    logic          out_ready;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          out_valid;
    logic [DW-1:0] y;
    logic          busy;

    logic [3:0]    gnt_b;
    logic [1:0]    sel_b;
    logic          out_valid_b;
    logic [DW-1:0] y_b;
    logic          busy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_BURST(4), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .out_ready(out_ready), .gnt(gnt), .sel(sel),
        .out_valid(out_valid), .y(y), .busy(busy)
    );

    mux4_rr_arbiter #(.MAX_BURST(1), .DW(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .out_ready(out_ready), .gnt(gnt_b), .sel(sel_b),
        .out_valid(out_valid_b), .y(y_b), .busy(busy_b)
    );

    function automatic logic [DW-1:0] dval(input int p);
        case (p)
            0: return 8'hA0;
            1: return 8'hB1;
            2: return 8'hC2;
            default: return 8'hD3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'h0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'hF;
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b sel=%0d ov=%b busy=%b want 0000/0/0/0", gnt, sel, out_valid, busy);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant: gnt=%b sel=%0d busy=%b want 0001/0/1", gnt, sel, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        out_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            total++;
            if (gnt !== 4'b0100 || sel !== 2'd2 || out_valid !== 1'b1 || y !== 8'hC2) begin
                bad++;
                $display("FAIL single_beat%0d: gnt=%b sel=%0d ov=%b y=%h want 0100/2/1/c2", b, gnt, sel, out_valid, y);
            end
            tick();
        end
        total++;
        if (gnt !== 4'b0000 || sel !== 2'd2 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: gnt=%b sel=%0d ov=%b busy=%b want 0000/2/0/0", gnt, sel, out_valid, busy);
        end
        tick();
        total++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            bad++;
            $display("FAIL single_regrant: gnt=%b sel=%0d want 0100/2", gnt, sel);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'hF;
        out_ready = 1'b1;
        tick();
        for (int g = 0; g < 6; g++) begin
            int p;
            p = g % 4;
            for (int b = 0; b < 4; b++) begin
                total++;
                if (gnt !== (4'b0001 << p) || sel !== 2'(p) || out_valid !== 1'b1 || y !== dval(p)) begin
                    bad++;
                    $display("FAIL rr_grant%0d_beat%0d: gnt=%b sel=%0d ov=%b y=%h want port %0d y=%h",
                             g, b, gnt, sel, out_valid, y, p, dval(p));
                end
                tick();
            end
            total++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rr_gap%0d: gnt=%b busy=%b want 0000/0", g, gnt, busy);
            end
            tick();
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 4'b0110;
        out_ready = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL drop_grant: gnt=%b want 0010", gnt);
        end
        tick();
        tick();
        req = 4'b0100;
        #1;
        total++;
        if (out_valid !== 1'b0 || gnt !== 4'b0010) begin
            bad++;
            $display("FAIL drop_valid: ov=%b gnt=%b want 0/0010", out_valid, gnt);
        end
        tick();
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL drop_release: gnt=%b want 0000", gnt);
        end
        tick();
        total++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            bad++;
            $display("FAIL drop_next: gnt=%b sel=%0d want 0100/2", gnt, sel);
        end
        do_reset();
        req = 4'b0010;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        req = 4'b0001;
        tick();
        tick();
        total++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            bad++;
            $display("FAIL drop_wrap: gnt=%b sel=%0d want 0001/0", gnt, sel);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0001;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (gnt !== 4'b0001 || sel !== 2'd0 || out_valid !== 1'b1 || y !== 8'hA0) begin
                bad++;
                $display("FAIL bp_hold%0d: gnt=%b sel=%0d ov=%b y=%h want 0001/0/1/a0", c, gnt, sel, out_valid, y);
            end
        end
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL bp_resume: gnt=%b want 0001", gnt);
        end
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_complete: gnt=%b busy=%b want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        out_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) tick();
        req = 4'b1000;
        tick();
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL areset_pre: gnt=%b want 1000", gnt);
        end
        req = 4'hF;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL areset_now: gnt=%b sel=%0d ov=%b busy=%b want 0000/0/0/0", gnt, sel, out_valid, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            bad++;
            $display("FAIL areset_ptr: gnt=%b sel=%0d want 0001/0", gnt, sel);
        end
    endtask

    task automatic test_burst1();
        do_reset();
        req = 4'b0011;
        out_ready = 1'b1;
        tick();
        total++;
        if (gnt_b !== 4'b0001 || out_valid_b !== 1'b1 || y_b !== 8'hA0) begin
            bad++;
            $display("FAIL b1_first: gnt=%b ov=%b y=%h want 0001/1/a0", gnt_b, out_valid_b, y_b);
        end
        tick();
        total++;
        if (gnt_b !== 4'b0000) begin
            bad++;
            $display("FAIL b1_release: gnt=%b want 0000", gnt_b);
        end
        tick();
        total++;
        if (gnt_b !== 4'b0010 || y_b !== 8'hB1) begin
            bad++;
            $display("FAIL b1_second: gnt=%b y=%h want 0010/b1", gnt_b, y_b);
        end
        tick();
        total++;
        if (gnt_b !== 4'b0000) begin
            bad++;
            $display("FAIL b1_release2: gnt=%b want 0000", gnt_b);
        end
    endtask

    initial begin
        d0 = dval(0);
        d1 = dval(1);
        d2 = dval(2);
        d3 = dval(3);
        rst_n = 1'b0;
        req = 4'h0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_early_drop();
        test_backpressure();
        test_async_reset();
        test_burst1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
